tact_decoder: RTL and testbench

Input-side companion to the LED chaser: converts the raw, bouncing, active-low tact switch into clean single-cycle key events on the 24 MHz board clock. It synchronizes and debounces the switch, then classifies each press as press, long-press and release, with optional auto-repeat. Control logic such as the chaser state machine consumes these events instead of sampling the raw switch level.

---
 rtl/tact_pkg.sv | 22 ++
 rtl/tact_sync.sv | 36 +++
 rtl/tact_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_tact_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tact_pkg.sv
// -----------------------------------------------------------------------------
// tact_pkg
// Shared constants for the tact switch decoder:
//   TACT_ON / TACT_OFF : raw switch levels (the switch is active-low)
//   ST_*               : 3-bit FSM state encoding used by tact_decoder
//   tact_state_t       : type that holds one of the ST_* codes
// No ports (package).
// -----------------------------------------------------------------------------
package tact_pkg;

  localparam logic TACT_ON  = 1'b0;
  localparam logic TACT_OFF = 1'b1;

  typedef logic [2:0] tact_state_t;

  localparam tact_state_t ST_REL     = 3'd0;
  localparam tact_state_t ST_PCHK    = 3'd1;
  localparam tact_state_t ST_PRESSED = 3'd2;
  localparam tact_state_t ST_LONG    = 3'd3;
  localparam tact_state_t ST_RCHK    = 3'd4;

endpackage

// File: rtl/tact_sync.sv
// -----------------------------------------------------------------------------
// tact_sync
// Two-flop synchronizer for the asynchronous tact switch input. Both flops
// reset to TACT_OFF so a reset never looks like a press.
// Ports:
//   clk_i : board clock
//   rst_i : asynchronous active-high reset
//   d_i   : raw switch level
//   q_o   : synchronized switch level
// -----------------------------------------------------------------------------
module tact_sync
  import tact_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= TACT_OFF;
      sync_q <= TACT_OFF;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tact_decoder.sv
// -----------------------------------------------------------------------------
// tact_decoder
// Turns the raw, bouncing, active-low tact switch into clean one-cycle key
// events: press, long-press, optional auto-repeat and release.
// Optional feature macro: TACT_REPEAT_EN (auto-repeat while in the long state).
// Without it repeat_o is tied low and the repeat counter is not built.
// Parameters:
//   DB_CYCLES     : stable cycles needed to accept an edge (2..2^W_CNT-1)
//   LONG_CYCLES   : debounced hold cycles before the long event
//   REPEAT_CYCLES : auto-repeat period in the long state
//   W_CNT         : width of the internal counters
// Ports:
//   CLK_24MHz : board clock (single clock domain)
//   RST       : asynchronous active-high reset
//   Tact1     : raw switch, low while pressed
//   pressed_o : debounced level, high while the key is accepted as held
//   press_o   : one-cycle pulse on an accepted press
//   long_o    : one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_o  : one-cycle auto-repeat pulse
//   release_o : one-cycle pulse on an accepted release
// -----------------------------------------------------------------------------
module tact_decoder
  import tact_pkg::*;
#(
  parameter int DB_CYCLES     = 240000,
  parameter int LONG_CYCLES   = 24000000,
  parameter int REPEAT_CYCLES = 4800000,
  parameter int W_CNT         = 25
) (
  input  logic CLK_24MHz,
  input  logic RST,
  input  logic Tact1,
  output logic pressed_o,
  output logic press_o,
  output logic long_o,
  output logic repeat_o,
  output logic release_o
);

  localparam logic [W_CNT-1:0] CNT_ONE   = W_CNT'(1);
  localparam logic [W_CNT-1:0] DB_LAST   = W_CNT'(DB_CYCLES - 1);
  localparam logic [W_CNT-1:0] LONG_LAST = W_CNT'(LONG_CYCLES - 1);
  localparam logic [W_CNT-1:0] REP_LAST  = W_CNT'(REPEAT_CYCLES - 1);

  logic s;

  tact_state_t      state_q, state_d;
  logic [W_CNT-1:0] db_cnt_q, db_cnt_d;
  logic [W_CNT-1:0] hold_cnt_q, hold_cnt_d;
  logic             was_long_q, was_long_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             long_q, long_d;
  logic             release_q, release_d;

  tact_sync u_sync (
    .clk_i (CLK_24MHz),
    .rst_i (RST),
    .d_i   (Tact1),
    .q_o   (s)
  );

  // Main key FSM. db_cnt is shared by the press and release checks since
  // only one of them can be active at a time. hold_cnt is left untouched in
  // ST_RCHK so a release glitch does not restart the long-press timer.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    was_long_d = was_long_q;
    pressed_d  = pressed_q;
    press_d    = 1'b0;
    long_d     = 1'b0;
    release_d  = 1'b0;

    case (state_q)
      ST_REL: begin
        pressed_d = 1'b0;
        if (s == TACT_ON) begin
          state_d  = ST_PCHK;
          db_cnt_d = '0;
        end
      end

      ST_PCHK: begin
        if (s == TACT_OFF) begin
          state_d = ST_REL;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_PRESSED;
          press_d    = 1'b1;
          pressed_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end

      // A release seen in the same cycle as the long terminal count wins.
      ST_PRESSED: begin
        if (s == TACT_OFF) begin
          state_d    = ST_RCHK;
          db_cnt_d   = '0;
          was_long_d = 1'b0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end

      ST_LONG: begin
        if (s == TACT_OFF) begin
          state_d    = ST_RCHK;
          db_cnt_d   = '0;
          was_long_d = 1'b1;
        end
      end

      ST_RCHK: begin
        if (s == TACT_ON) begin
          state_d = was_long_q ? ST_LONG : ST_PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_REL;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d   = ST_REL;
        pressed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_24MHz or posedge RST) begin
    if (RST) begin
      state_q    <= ST_REL;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      was_long_q <= 1'b0;
      pressed_q  <= 1'b0;
      press_q    <= 1'b0;
      long_q     <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      was_long_q <= was_long_d;
      pressed_q  <= pressed_d;
      press_q    <= press_d;
      long_q     <= long_d;
      release_q  <= release_d;
    end
  end

  assign pressed_o = pressed_q;
  assign press_o   = press_q;
  assign long_o    = long_q;
  assign release_o = release_q;

`ifdef TACT_REPEAT_EN
  logic [W_CNT-1:0] rep_cnt_q, rep_cnt_d;
  logic             repeat_q, repeat_d;

  // Auto-repeat timer. It restarts on the long event, runs only in ST_LONG
  // and therefore holds its value while a release is being confirmed.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    repeat_d  = 1'b0;
    if (long_d) begin
      rep_cnt_d = '0;
    end else if (state_q == ST_LONG) begin
      if (rep_cnt_q == REP_LAST) begin
        repeat_d  = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK_24MHz or posedge RST) begin
    if (RST) begin
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  logic unused_rep_last;

  assign repeat_o        = 1'b0;
  assign unused_rep_last = ^REP_LAST;
`endif

endmodule

// File: tb/tb_tact_decoder.sv
// -----------------------------------------------------------------------------
// tb_tact_decoder
// Self-checking bench for tact_decoder with DB_CYCLES=4, LONG_CYCLES=20,
// REPEAT_CYCLES=5, W_CNT=8. Expected event pulses (kind + cycle) are queued
// when the stimulus is driven and matched by a monitor as pulses appear.
// Repeat expectations depend on TACT_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_tact_decoder;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;
  localparam int W    = 8;

  // Spec latency: edge-count from the first sampling edge to the event.
  localparam int LAT  = DB + 3;

  localparam int EV_NONE    = -1;
  localparam int EV_PRESS   = 0;
  localparam int EV_LONG    = 1;
  localparam int EV_REPEAT  = 2;
  localparam int EV_RELEASE = 3;

  logic clk = 1'b0;
  logic rst;
  logic tact;
  logic pressed_o, press_o, long_o, repeat_o, release_o;
  logic [3:0] pulses;

  int cyc = 0;
  int total = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t expQ[$];

  typedef struct {
    logic level;
    int   cycles;
    int   k0;
    int   o0;
    int   k1;
    int   o1;
    logic expPressed;
  } vec_t;

  vec_t vecs[$];

  tact_decoder #(
    .DB_CYCLES     (DB),
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .W_CNT         (W)
  ) dut (
    .CLK_24MHz (clk),
    .RST       (rst),
    .Tact1     (tact),
    .pressed_o (pressed_o),
    .press_o   (press_o),
    .long_o    (long_o),
    .repeat_o  (repeat_o),
    .release_o (release_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign pulses = {release_o, repeat_o, long_o, press_o};

  function automatic vec_t mk(logic level, int cycles, int k0, int o0,
                              int k1, int o1, logic expPressed);
    vec_t v;
    v.level      = level;
    v.cycles     = cycles;
    v.k0         = k0;
    v.o0         = o0;
    v.k1         = k1;
    v.o1         = o1;
    v.expPressed = expPressed;
    return v;
  endfunction

  task automatic pushEv(int kind, int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(string name, int actual, int expected);
    total++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, actual, expected);
    end
  endtask

  // Drive one level for a number of cycles starting at the current negedge.
  task automatic applyStimulus(logic level, int cycles, int k0, int o0, int k1, int o1);
    int c0;
    c0   = cyc;
    tact = level;
    if (k0 != EV_NONE) pushEv(k0, c0 + o0);
    if (k1 != EV_NONE) pushEv(k1, c0 + o1);
    repeat (cycles) @(negedge clk);
  endtask

  // Matches every observed pulse against the queue head and flags expected
  // pulses whose cycle has gone by without them.
  task automatic monitorEvents();
    ev_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0 && expQ[0].at < cyc) begin
        e = expQ.pop_front();
        total++;
        fails++;
        $display("[TB] FAIL missed_event kind %0d: got no pulse at cycle %0d, required one", e.kind, e.at);
      end
      for (int k = 0; k < 4; k++) begin
        if (pulses[k]) begin
          total++;
          if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, required no pulse", k, cyc);
          end else begin
            e = expQ.pop_front();
            if (e.kind != k || e.at != cyc) begin
              fails++;
              $display("[TB] FAIL event_match: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                       k, cyc, e.kind, e.at);
            end
          end
        end
      end
    end
  endtask

  initial begin
    int c0;

    rst  = 1'b1;
    tact = 1'b0;

    // Clean press / release.
    vecs.push_back(mk(1'b0, 10, EV_PRESS,   LAT, EV_NONE, 0, 1'b1));
    vecs.push_back(mk(1'b1, 10, EV_RELEASE, LAT, EV_NONE, 0, 1'b0));
    // Bounce: low 2 / high 2 five times, then stays high.
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(1'b0, 2, EV_NONE, 0, EV_NONE, 0, 1'b0));
      vecs.push_back(mk(1'b1, 2, EV_NONE, 0, EV_NONE, 0, 1'b0));
    end
    vecs.push_back(mk(1'b1, 10, EV_NONE, 0, EV_NONE, 0, 1'b0));
    // Release glitch during a hold.
    vecs.push_back(mk(1'b0, 10, EV_PRESS,   LAT, EV_NONE, 0, 1'b1));
    vecs.push_back(mk(1'b1,  2, EV_NONE,    0,   EV_NONE, 0, 1'b1));
    vecs.push_back(mk(1'b0,  6, EV_NONE,    0,   EV_NONE, 0, 1'b1));
    vecs.push_back(mk(1'b1, 10, EV_RELEASE, LAT, EV_NONE, 0, 1'b0));
    // Long press released before the first repeat would be due.
    vecs.push_back(mk(1'b0, 28, EV_PRESS,   LAT, EV_LONG, LAT + LONG, 1'b1));
    vecs.push_back(mk(1'b1, 10, EV_RELEASE, LAT, EV_NONE, 0, 1'b0));

    fork
      monitorEvents();
    join_none

    // Reset held with the key down: everything stays quiet.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_outputs", int'(pulses), 0);
      checkOutput("reset_pressed", int'(pressed_o), 0);
    end

    // Key still held after reset: fresh press after the full debounce.
    rst = 1'b0;
    c0  = cyc;
    pushEv(EV_PRESS, c0 + LAT);
    repeat (10) @(negedge clk);
    checkOutput("post_reset_pressed", int'(pressed_o), 1);
    applyStimulus(1'b1, 10, EV_RELEASE, LAT, EV_NONE, 0);
    checkOutput("post_reset_released", int'(pressed_o), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].level, vecs[i].cycles, vecs[i].k0, vecs[i].o0, vecs[i].k1, vecs[i].o1);
      checkOutput($sformatf("vec%0d_pressed", i), int'(pressed_o), int'(vecs[i].expPressed));
    end

    // Long press held for 60 cycles, then reset while in the long state.
    c0   = cyc;
    tact = 1'b0;
    pushEv(EV_PRESS, c0 + LAT);
    pushEv(EV_LONG,  c0 + LAT + LONG);
`ifdef TACT_REPEAT_EN
    for (int t = c0 + LAT + LONG + REP; t < c0 + 60; t += REP) pushEv(EV_REPEAT, t);
`endif
    repeat (60) @(negedge clk);
    checkOutput("long_hold_pressed", int'(pressed_o), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midop_reset_outputs", int'(pulses), 0);
    checkOutput("midop_reset_pressed", int'(pressed_o), 0);
    tact = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("after_midop_pressed", int'(pressed_o), 0);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end

endmodule
